// File: rtl/alu_pkg.sv
// Shared encodings for the multicycle ALU: operation codes and controller states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_OR     = 4'd2,
    OP_AND    = 4'd3,
    OP_LUI    = 4'd4,
    OP_NOR    = 4'd5,
    OP_SLL    = 4'd6,
    OP_SRL    = 4'd7,
    OP_BRANCH = 4'd8,
    OP_JR     = 4'd9,
    OP_SLT    = 4'd10,
    OP_MULTU  = 4'd11,
    OP_DIVU   = 4'd12,
    OP_MFHI   = 4'd13,
    OP_MFLO   = 4'd14,
    OP_RSVD   = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } alu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// A single 2*WIDTH register holds {upper, lower}: for multiply that ends as
// {hi, lo} of the product, for divide as {remainder, quotient}.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               running_q, running_d;
  logic               isDiv_q, isDiv_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divDiff;
  logic [WIDTH:0]     divShifted;

  // One iteration step of each algorithm, computed from the current register.
  always_comb begin
    mulSum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    divShifted = prod_q[2*WIDTH-1:WIDTH-1];
    divDiff    = divShifted - {1'b0, opnd_q};
  end

  // Load on start, then iterate exactly WIDTH times and pulse done once.
  always_comb begin
    prod_d    = prod_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    running_d = running_q;
    isDiv_d   = isDiv_q;
    done_d    = 1'b0;
    if (start_i && !running_q) begin
      prod_d    = {{WIDTH{1'b0}}, a_i};
      opnd_d    = b_i;
      isDiv_d   = is_div_i;
      cnt_d     = '0;
      running_d = 1'b1;
    end else if (running_q) begin
      if (isDiv_q) begin
        if (!divDiff[WIDTH]) begin
          prod_d = {divDiff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end else begin
          prod_d = {prod_q[2*WIDTH-2:0], 1'b0};
        end
      end else begin
        prod_d = {mulSum, prod_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        running_d = 1'b0;
        done_d    = 1'b1;
      end
    end
  end

  // Iteration state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prod_q    <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      isDiv_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      prod_q    <= prod_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      isDiv_q   <= isDiv_d;
      done_q    <= done_d;
    end
  end

  assign done_o = done_q;
  assign hi_o   = prod_q[2*WIDTH-1:WIDTH];
  assign lo_o   = prod_q[WIDTH-1:0];

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle ops pass through EXEC, MULTU/DIVU iterate in
// mul_div_unit. Results are registered on entry to DONE and held until the next done.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         alu_op,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   alu_result,
  output logic               zero,
  output logic               is_jr,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               div_by_zero
);

  alu_state_e         state_q, state_d;
  alu_op_e            op_q;
  logic [WIDTH-1:0]   rs_q, a_q, b_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [WIDTH-1:0]   aluResult_q, aluResult_d;
  logic               zero_q, zero_d;
  logic               isJr_q, isJr_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               divByZero_q, divByZero_d;
  logic [WIDTH-1:0]   execRes;
  logic [WIDTH-1:0]   branchDiff;
  logic               mdStart, mdDone;
  logic [WIDTH-1:0]   mdHi, mdLo;

  // Next-state logic; DIVU by zero takes the short EXEC path instead of iterating.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (alu_op_e'(alu_op))
            OP_MULTU: state_d = S_MUL;
            OP_DIVU:  state_d = (b != '0) ? S_DIV : S_EXEC;
            default:  state_d = S_EXEC;
          endcase
        end
      end
      S_EXEC:       state_d = S_DONE;
      S_MUL, S_DIV: if (mdDone) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Kick the iterative unit on the same edge that accepts MULTU/DIVU.
  always_comb begin
    mdStart = (state_q == S_IDLE) && ((state_d == S_MUL) || (state_d == S_DIV));
  end

  mul_div_unit #(.WIDTH(WIDTH)) u_mul_div (
    .clk_i   (clk),
    .rst_ni  (reset),
    .start_i (mdStart),
    .is_div_i(alu_op_e'(alu_op) == OP_DIVU),
    .a_i     (a),
    .b_i     (b),
    .done_o  (mdDone),
    .hi_o    (mdHi),
    .lo_o    (mdLo)
  );

  // Result computation; registers only change on the edge that enters DONE.
  always_comb begin
    aluResult_d = aluResult_q;
    zero_d      = zero_q;
    isJr_d      = isJr_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    divByZero_d = divByZero_q;
    execRes     = '0;
    branchDiff  = rs_q - a_q;
    if (state_q == S_EXEC) begin
      isJr_d = 1'b0;
      case (op_q)
        OP_ADD:    execRes = a_q + b_q;
        OP_SUB:    execRes = a_q - b_q;
        OP_OR:     execRes = a_q | b_q;
        OP_AND:    execRes = a_q & b_q;
        OP_LUI:    execRes = {b_q[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
        OP_NOR:    execRes = ~(a_q | b_q);
        OP_SLL:    execRes = a_q << shamt_q;
        OP_SRL:    execRes = a_q >> shamt_q;
        OP_BRANCH: execRes = rs_q;
        OP_JR: begin
          execRes = a_q;
          isJr_d  = 1'b1;
        end
        OP_SLT:    execRes = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
        OP_DIVU: begin
          execRes     = '1;
          hi_d        = a_q;
          lo_d        = '1;
          divByZero_d = 1'b1;
        end
        OP_MFHI:   execRes = hi_q;
        OP_MFLO:   execRes = lo_q;
        default:   execRes = '0;
      endcase
      aluResult_d = execRes;
      zero_d      = (op_q == OP_BRANCH) ? (branchDiff == '0) : (execRes == '0);
    end else if (((state_q == S_MUL) || (state_q == S_DIV)) && mdDone) begin
      aluResult_d = mdLo;
      zero_d      = (mdLo == '0);
      isJr_d      = 1'b0;
      hi_d        = mdHi;
      lo_d        = mdLo;
      if (state_q == S_DIV) divByZero_d = 1'b0;
    end
  end

  // State, operand capture and result registers; reset wins over start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      rs_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      shamt_q     <= '0;
      aluResult_q <= '0;
      zero_q      <= 1'b0;
      isJr_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      divByZero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && start) begin
        op_q    <= alu_op_e'(alu_op);
        rs_q    <= rs;
        a_q     <= a;
        b_q     <= b;
        shamt_q <= shamt;
      end
      aluResult_q <= aluResult_d;
      zero_q      <= zero_d;
      isJr_q      <= isJr_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      divByZero_q <= divByZero_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign alu_result  = aluResult_q;
  assign zero        = zero_q;
  assign is_jr       = isJr_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = divByZero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle with hand-computed expected values.
module tb_alu_multicycle;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] rs, a, b;
  logic [SHW-1:0]   shamt;
  logic             busy, done, zero, is_jr, div_by_zero;
  logic [WIDTH-1:0] alu_result, hi, lo;

  int checkCount = 0;
  int failCount  = 0;
  int lat;
  int doneCount;

  alu_multicycle #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op),
    .rs(rs), .a(a), .b(b), .shamt(shamt),
    .busy(busy), .done(done), .alu_result(alu_result), .zero(zero),
    .is_jr(is_jr), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Counts every comparison and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one operation and waits (bounded) for done; lat counts rising edges
  // from the start edge up to the edge after which done is seen.
  task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] rsV,
                               input logic [WIDTH-1:0] aV, input logic [WIDTH-1:0] bV,
                               input logic [SHW-1:0] shV);
    @(negedge clk);
    alu_op = op; rs = rsV; a = aV; b = bV; shamt = shV; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Runs a single-cycle op and checks latency, result, zero and is_jr.
  task automatic runSimple(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] rsV,
                           input logic [WIDTH-1:0] aV, input logic [WIDTH-1:0] bV,
                           input logic [SHW-1:0] shV, input logic [WIDTH-1:0] expRes,
                           input logic expZero, input logic expJr);
    applyStimulus(op, rsV, aV, bV, shV);
    checkOutput({tag, "_lat"}, 64'(lat), 64'd2);
    checkOutput({tag, "_res"}, 64'(alu_result), 64'(expRes));
    checkOutput({tag, "_zero"}, 64'(zero), 64'(expZero));
    checkOutput({tag, "_jr"}, 64'(is_jr), 64'(expJr));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; alu_op = '0; rs = '0; a = '0; b = '0; shamt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_res", 64'(alu_result), 64'd0);
    checkOutput("rst_zero", 64'(zero), 64'd0);
    checkOutput("rst_jr", 64'(is_jr), 64'd0);
    checkOutput("rst_hilo", {hi, lo}, 64'd0);
    checkOutput("rst_dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b1;

    runSimple("add_ovf", 4'd0, 0, 32'h7FFF_FFFF, 32'd1, 0, 32'h8000_0000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("add_done_pulse", 64'(done), 64'd0);
    checkOutput("add_idle", 64'(busy), 64'd0);
    runSimple("sub_zero", 4'd1, 0, 32'd5, 32'd5, 0, 32'd0, 1'b1, 1'b0);
    runSimple("or", 4'd2, 0, 32'hF0F0_0000, 32'h0000_0F0F, 0, 32'hF0F0_0F0F, 1'b0, 1'b0);
    runSimple("and", 4'd3, 0, 32'hFF00_FF00, 32'h0F0F_0F0F, 0, 32'h0F00_0F00, 1'b0, 1'b0);
    runSimple("lui", 4'd4, 0, 32'd0, 32'hABCD_1234, 0, 32'h1234_0000, 1'b0, 1'b0);
    runSimple("nor", 4'd5, 0, 32'd0, 32'd0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    runSimple("sll", 4'd6, 0, 32'd1, 32'd0, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    runSimple("srl", 4'd7, 0, 32'h8000_0000, 32'd0, 5'd4, 32'h0800_0000, 1'b0, 1'b0);
    runSimple("slt_t", 4'd10, 0, 32'hFFFF_FFFF, 32'd1, 0, 32'd1, 1'b0, 1'b0);
    runSimple("slt_f", 4'd10, 0, 32'd1, 32'hFFFF_FFFF, 0, 32'd0, 1'b1, 1'b0);
    runSimple("br_eq", 4'd8, 32'd5, 32'd5, 32'd9, 0, 32'd5, 1'b1, 1'b0);
    runSimple("br_ne", 4'd8, 32'd5, 32'd3, 32'd0, 0, 32'd5, 1'b0, 1'b0);
    runSimple("jr", 4'd9, 0, 32'h0000_0400, 32'd0, 0, 32'h0000_0400, 1'b0, 1'b1);
    runSimple("op15", 4'd15, 32'd7, 32'd9, 32'd11, 0, 32'd0, 1'b1, 1'b0);

    applyStimulus(4'd11, 0, 32'hFFFF_FFFF, 32'd2, 0);
    checkOutput("mul_lat", 64'(lat), 64'd34);
    checkOutput("mul_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    checkOutput("mul_res", 64'(alu_result), 64'hFFFF_FFFE);
    runSimple("mfhi", 4'd13, 0, 0, 0, 0, 32'd1, 1'b0, 1'b0);
    runSimple("mflo", 4'd14, 0, 0, 0, 0, 32'hFFFF_FFFE, 1'b0, 1'b0);

    applyStimulus(4'd12, 0, 32'd100, 32'd7, 0);
    checkOutput("div_lat", 64'(lat), 64'd34);
    checkOutput("div_hilo", {hi, lo}, {32'd2, 32'd14});
    checkOutput("div_res", 64'(alu_result), 64'd14);
    checkOutput("div_dbz", 64'(div_by_zero), 64'd0);
    applyStimulus(4'd12, 0, 32'd100, 32'd0, 0);
    checkOutput("dz_lat", 64'(lat), 64'd2);
    checkOutput("dz_hilo", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
    checkOutput("dz_dbz", 64'(div_by_zero), 64'd1);
    checkOutput("dz_res", 64'(alu_result), 64'hFFFF_FFFF);
    applyStimulus(4'd12, 0, 32'd9, 32'd3, 0);
    checkOutput("div2_hilo", {hi, lo}, {32'd0, 32'd3});
    checkOutput("div2_dbz", 64'(div_by_zero), 64'd0);

    // Start pulse and operand changes during a MULTU must be ignored.
    @(negedge clk);
    alu_op = 4'd11; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 45; i++) begin
      if (i == 5) begin
        alu_op = 4'd0; a = 32'd77; b = 32'd1000; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (done) doneCount++;
    end
    start = 1'b0;
    checkOutput("busy_ign_done", 64'(doneCount), 64'd1);
    checkOutput("busy_ign_hilo", {hi, lo}, {32'd0, 32'd15});
    checkOutput("busy_ign_idle", 64'(busy), 64'd0);

    // Reset in the middle of a DIVU, with a start request in the same cycle.
    @(negedge clk);
    alu_op = 4'd12; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b1; alu_op = 4'd0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_done", 64'(done), 64'd0);
    checkOutput("mid_rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b1; start = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) doneCount++;
    end
    checkOutput("mid_rst_nodone", 64'(doneCount), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
